// File: rtl/wb_arb_pkg.sv
// Shared types and constant helpers for the Wishbone DRAM-port arbiter.
// The optional stall watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Width of a master index; never zero so a single-master build still has a legal vector.
    function automatic int idx_w(input int num_masters);
        return (num_masters > 1) ? clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin pick: the first requester strictly after the
// last-granted index wins, wrapping around; result is one-hot plus its index.
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W:0] rot_amt;
    logic [IDX_W:0] back_amt;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;

    // Rotate so the master after last_i sits at bit 0, take the lowest set
    // bit, then rotate the single bit back into master numbering.
    always_comb begin
        rot_amt  = (IDX_W+1)'(last_i) + (IDX_W+1)'(1);
        back_amt = (IDX_W+1)'(N) - rot_amt;
        rot_req  = N'({req_i, req_i} >> rot_amt);
        rot_gnt  = rot_req & (~rot_req + N'(1));
        grant_o  = N'({rot_gnt, rot_gnt} >> back_amt);
    end

    always_comb begin
        grant_idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                grant_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter for the 128-bit DRAM user port.
// Round-robin, burst-holding grant; define WB_ARB_TIMEOUT_EN for the stall watchdog.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 128,
    parameter  int TIMEOUT     = 1024,
    localparam int SEL_W       = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
    output logic [DATA_W-1:0]             m_dat_o,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [ADDR_W-1:0]             s_adr_o,
    output logic [DATA_W-1:0]             s_dat_o,
    output logic                          s_we_o,
    output logic [SEL_W-1:0]              s_sel_o,
    output logic                          s_stb_o,
    output logic                          s_cyc_o,
    input  logic [DATA_W-1:0]             s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int IDX_W = idx_w(NUM_MASTERS);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       last_q, last_d;

    logic [NUM_MASTERS-1:0] rr_grant;
    logic [IDX_W-1:0]       rr_idx;

    logic                   cyc_g;
    logic                   stb_g;
    logic                   we_g;
    logic [ADDR_W-1:0]      adr_g;
    logic [DATA_W-1:0]      dat_g;
    logic [SEL_W-1:0]       sel_g;
    logic                   timeout_hit;

    logic [ADDR_W-1:0]      adr_term [NUM_MASTERS];
    logic [DATA_W-1:0]      dat_term [NUM_MASTERS];
    logic [SEL_W-1:0]       sel_term [NUM_MASTERS];

    rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_rr (
        .req_i       (m_cyc_i),
        .last_i      (last_q),
        .grant_o     (rr_grant),
        .grant_idx_o (rr_idx)
    );

    // AND-OR mux on the one-hot grant; grant is all-zero outside BUSY so the slave side idles at 0.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mux
        assign adr_term[gi] = m_adr_i[gi*ADDR_W +: ADDR_W] & {ADDR_W{grant_q[gi]}};
        assign dat_term[gi] = m_dat_i[gi*DATA_W +: DATA_W] & {DATA_W{grant_q[gi]}};
        assign sel_term[gi] = m_sel_i[gi*SEL_W +: SEL_W]   & {SEL_W{grant_q[gi]}};
    end

    always_comb begin
        adr_g = '0;
        dat_g = '0;
        sel_g = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            adr_g = adr_g | adr_term[i];
            dat_g = dat_g | dat_term[i];
            sel_g = sel_g | sel_term[i];
        end
    end

    assign cyc_g = |(m_cyc_i & grant_q);
    assign stb_g = |(m_stb_i & grant_q);
    assign we_g  = |(m_we_i  & grant_q);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts strobed cycles still waiting on the slave; any response or release restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != BUSY) || s_ack_i || s_err_i || timeout_hit) begin
            cnt_d = '0;
        end else if (stb_g) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = rr_grant;
                    gidx_d  = rr_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Owner keeps the bus for its whole cycle; release forces one idle bubble.
                if (!cyc_g || timeout_hit) begin
                    grant_d = '0;
                    last_d  = gidx_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    assign s_adr_o = adr_g;
    assign s_dat_o = dat_g;
    assign s_sel_o = sel_g;
    assign s_we_o  = we_g;
    assign s_cyc_o = cyc_g & ~timeout_hit;
    assign s_stb_o = stb_g & ~timeout_hit;

    // Responses reach only the owner, and only while it still holds cyc.
    assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i & cyc_g & ~timeout_hit}};
    assign m_err_o = grant_q & {NUM_MASTERS{(s_err_i & cyc_g) | timeout_hit}};
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: randomized bursts against a
// round-robin reference model kept in the bench.
module tb_wb_mem_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic [NM*AW-1:0]  m_adr_i;
    logic [NM*DW-1:0]  m_dat_i;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_we_i;
    logic [NM*SW-1:0]  m_sel_i;
    logic [NM-1:0]     m_stb_i;
    logic [NM-1:0]     m_cyc_i;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic              s_we_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_stb_o;
    logic              s_cyc_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i;
    logic              s_err_i;
    logic [NM-1:0]     grant_o;

    int checks = 0;
    int errors = 0;
    int model_last = NM - 1;

    logic [AW-1:0] exp_adr [NM];
    logic [DW-1:0] exp_dat [NM];
    logic [SW-1:0] exp_sel [NM];
    logic          exp_we  [NM];

    wb_mem_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_we_i  (m_we_i),
        .m_sel_i (m_sel_i),
        .m_stb_i (m_stb_i),
        .m_cyc_i (m_cyc_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_stb_o (s_stb_o),
        .s_cyc_o (s_cyc_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rule: first requester strictly after the last owner, wrapping.
    function automatic int rr_pick(input logic [NM-1:0] req, input int last);
        for (int off = 1; off <= NM; off++) begin
            int idx;
            idx = (last + off) % NM;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NM-1:0] onehot(input int w);
        logic [NM-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int k, input logic cyc, input logic we,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic [SW-1:0] sel);
        m_cyc_i[k]          = cyc;
        m_stb_i[k]          = cyc;
        m_we_i[k]           = we;
        m_adr_i[k*AW +: AW] = adr;
        m_dat_i[k*DW +: DW] = dat;
        m_sel_i[k*SW +: SW] = sel;
        exp_adr[k] = adr;
        exp_dat[k] = dat;
        exp_sel[k] = sel;
        exp_we[k]  = we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_cyc_i = '1;
        m_stb_i = '1;
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        tick();
        tick();
        checks++; if (grant_o !== '0) begin errors++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc_o); end
        checks++; if (m_ack_o !== '0) begin errors++; $display("FAIL reset_ack: got %b want 00", m_ack_o); end
        checks++; if (m_err_o !== '0) begin errors++; $display("FAIL reset_err: got %b want 00", m_err_o); end
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (grant_o !== onehot(rr_pick(2'b11, model_last)))
            begin errors++; $display("FAIL reset_first_grant: got %b want %b", grant_o, onehot(rr_pick(2'b11, model_last))); end
        checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL reset_first_cyc: got %b want 1", s_cyc_o); end
        model_last = rr_pick(2'b11, model_last);
        m_cyc_i = '0;
        m_stb_i = '0;
        tick();
        checks++; if (grant_o !== '0) begin errors++; $display("FAIL reset_release: got %b want 00", grant_o); end
        $display("[%0t] reset: first grant to M%0d", $time, model_last);
    endtask

    // Drives a set of simultaneous requesters to completion, one burst per master.
    task automatic run_round(input logic [NM-1:0] req, input int beats, input bit waits_on);
        logic [NM-1:0] pending;
        logic [DW-1:0] rd;
        int w;
        int nb;
        int nw;
        pending = req;
        for (int k = 0; k < NM; k++) begin
            if (req[k]) set_master(k, 1'b1, 1'($urandom_range(0, 1)), $urandom, rand_data(), SW'($urandom));
        end
        while (pending != '0) begin
            w  = rr_pick(pending, model_last);
            nb = (beats > 0) ? beats : int'($urandom_range(1, 4));
            tick();
            checks++; if (grant_o !== onehot(w)) begin errors++; $display("FAIL rr_grant: got %b want %b", grant_o, onehot(w)); end
            checks++; if (s_adr_o !== exp_adr[w] || s_we_o !== exp_we[w] || s_dat_o !== exp_dat[w] || s_sel_o !== exp_sel[w])
                begin errors++; $display("FAIL rr_mux: got adr %h we %b sel %h want adr %h we %b sel %h", s_adr_o, s_we_o, s_sel_o, exp_adr[w], exp_we[w], exp_sel[w]); end
            for (int b = 0; b < nb; b++) begin
                nw = waits_on ? int'($urandom_range(0, 2)) : 0;
                s_ack_i = 1'b0;
                for (int i = 0; i < nw; i++) begin
                    #1;
                    checks++; if (m_ack_o !== '0) begin errors++; $display("FAIL rr_wait_ack: got %b want 00", m_ack_o); end
                    tick();
                end
                rd = rand_data();
                s_ack_i = 1'b1;
                s_dat_i = rd;
                #1;
                checks++; if (m_ack_o !== onehot(w) || m_dat_o !== rd)
                    begin errors++; $display("FAIL rr_ack: got ack %b dat %h want ack %b dat %h", m_ack_o, m_dat_o, onehot(w), rd); end
                $display("[%0t] beat M%0d %0d/%0d adr=%h", $time, w, b + 1, nb, s_adr_o);
                tick();
            end
            s_ack_i = 1'b0;
            set_master(w, 1'b0, 1'b0, '0, '0, '0);
            #1;
            checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_drop_cyc: got %b want 0", s_cyc_o); end
            tick();
            checks++; if (grant_o !== '0) begin errors++; $display("FAIL rr_bubble: got %b want 00", grant_o); end
            model_last = w;
            pending[w] = 1'b0;
        end
    endtask

    task automatic test_m1_write();
        logic [DW-1:0] pat;
        pat = {16{8'hA5}};
        set_master(1, 1'b1, 1'b1, 32'h100, pat, 16'hFFFF);
        tick();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", grant_o); end
        checks++; if (s_adr_o !== 32'h100 || s_sel_o !== 16'hFFFF || s_we_o !== 1'b1)
            begin errors++; $display("FAIL wr_ctrl: got adr %h sel %h we %b want 100 ffff 1", s_adr_o, s_sel_o, s_we_o); end
        checks++; if (s_dat_o !== pat) begin errors++; $display("FAIL wr_data: got %h want %h", s_dat_o, pat); end
        s_ack_i = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b want 10", m_ack_o); end
        $display("[%0t] M1 write adr=%h sel=%h", $time, s_adr_o, s_sel_o);
        tick();
        s_ack_i = 1'b0;
        set_master(1, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checks++; if (grant_o !== '0) begin errors++; $display("FAIL wr_release: got %b want 00", grant_o); end
        model_last = 1;
    endtask

    task automatic test_error();
        set_master(0, 1'b1, 1'b0, $urandom, '0, '1);
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL err_grant: got %b want 01", grant_o); end
        s_err_i = 1'b1;
        #1;
        checks++; if (m_err_o !== 2'b01 || m_ack_o !== 2'b00)
            begin errors++; $display("FAIL err_resp: got err %b ack %b want 01 00", m_err_o, m_ack_o); end
        $display("[%0t] M0 read error adr=%h", $time, s_adr_o);
        tick();
        s_err_i = 1'b0;
        #1;
        checks++; if (m_err_o !== 2'b00) begin errors++; $display("FAIL err_pulse: got %b want 00", m_err_o); end
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL err_hold: got %b want 01", grant_o); end
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL err_release: got %b want 00", grant_o); end
        model_last = 0;
    endtask

    task automatic test_drop_early();
        set_master(0, 1'b1, 1'b0, $urandom, '0, '1);
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL drop_grant: got %b want 01", grant_o); end
        set_master(1, 1'b1, 1'b0, $urandom, '0, '1);
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL drop_s_cyc: got %b want 0", s_cyc_o); end
        tick();
        model_last = 0;
        s_ack_i = 1'b1;
        #1;
        checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL drop_late_ack: got %b want 00", m_ack_o); end
        tick();
        s_ack_i = 1'b0;
        checks++; if (grant_o !== onehot(rr_pick(2'b10, model_last)))
            begin errors++; $display("FAIL drop_next_grant: got %b want %b", grant_o, onehot(rr_pick(2'b10, model_last))); end
        $display("[%0t] M0 dropped early, late ack ignored, grant=%b", $time, grant_o);
        set_master(1, 1'b0, 1'b0, '0, '0, '0);
        tick();
        model_last = 1;
    endtask

    task automatic test_timeout();
        set_master(0, 1'b1, 1'b0, $urandom, '0, '1);
        tick();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL to_grant: got %b want 01", grant_o); end
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            tick();
            checks++; if (m_err_o !== 2'b00 || s_cyc_o !== 1'b1)
                begin errors++; $display("FAIL to_early: cycle %0d got err %b cyc %b want 00 1", c, m_err_o, s_cyc_o); end
        end
        tick();
        checks++; if (m_err_o !== 2'b01 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0)
            begin errors++; $display("FAIL to_fire: got err %b cyc %b stb %b want 01 0 0", m_err_o, s_cyc_o, s_stb_o); end
        tick();
        checks++; if (grant_o !== 2'b00 || m_err_o !== 2'b00)
            begin errors++; $display("FAIL to_idle: got grant %b err %b want 00 00", grant_o, m_err_o); end
        $display("[%0t] watchdog fired after %0d cycles", $time, TO);
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        tick();
`else
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 1000; c++) begin
                tick();
                if (m_err_o !== 2'b00 || grant_o !== 2'b01) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL to_none: %0d bad cycles want 0", bad); end
            $display("[%0t] no watchdog: held 1000 cycles", $time);
        end
        set_master(0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
`endif
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL to_release: got %b want 00", grant_o); end
        model_last = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            logic [NM-1:0] req;
            req = NM'($urandom_range(1, (1 << NM) - 1));
            $display("[%0t] random round %0d req=%b", $time, r, req);
            run_round(req, 0, 1'b1);
        end
    endtask

    initial begin
        m_adr_i = '0;
        m_dat_i = '0;
        m_we_i  = '0;
        m_sel_i = '0;
        m_stb_i = '0;
        m_cyc_i = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        rst     = 1'b1;
        test_reset();
        test_m1_write();
        run_round(2'b11, 4, 1'b0);
        run_round(2'b11, 4, 1'b0);
        test_error();
        test_drop_early();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
